// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for requests arriving from foreign clock domains.
// Each request is double-flopped, and a watchdog ends any grant held longer than HOLD_MAX cycles.
module sync_req_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         async_req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] sync_stage1, sync_req;
    logic [NUM_REQ-1:0] lockout, lockout_next;
    logic [ID_W-1:0]    last_grant, last_grant_next;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [ID_W-1:0]    grant_id_next;
    logic               busy_next, timeout_next;
    logic [NUM_REQ-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               win_found;
    logic               granted_req;
    logic               hold_expired;

    assign eligible     = sync_req & ~lockout;
    assign granted_req  = |(sync_req & grant);
    assign hold_expired = (hold_cnt == CNT_W'(HOLD_MAX));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= IDLE;
            sync_stage1 <= '0;
            sync_req    <= '0;
            lockout     <= '0;
            last_grant  <= ID_W'(NUM_REQ - 1);
            hold_cnt    <= '0;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            sync_stage1 <= async_req;
            sync_req    <= sync_stage1;
            lockout     <= lockout_next;
            last_grant  <= last_grant_next;
            hold_cnt    <= hold_cnt_next;
            grant       <= grant_next;
            grant_id    <= grant_id_next;
            busy        <= busy_next;
            timeout     <= timeout_next;
        end
    end

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        int idx;
        winner    = '0;
        win_found = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                winner    = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = GRANT;
            GRANT:   if (!granted_req || hold_expired) state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A lockout only clears once its synchronized request has been seen low.
    always_comb begin
        grant_next      = '0;
        grant_id_next   = '0;
        busy_next       = 1'b0;
        timeout_next    = 1'b0;
        hold_cnt_next   = '0;
        last_grant_next = last_grant;
        lockout_next    = lockout & sync_req;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant_next      = NUM_REQ'(1) << winner;
                    grant_id_next   = winner;
                    busy_next       = 1'b1;
                    hold_cnt_next   = CNT_W'(1);
                    last_grant_next = winner;
                end
            end
            GRANT: begin
                if (!granted_req) begin
                    grant_next = '0;
                end else if (hold_expired) begin
                    timeout_next = 1'b1;
                    lockout_next = lockout_next | grant;
                end else begin
                    grant_next    = grant;
                    grant_id_next = grant_id;
                    busy_next     = 1'b1;
                    hold_cnt_next = hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                grant_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed bench for sync_req_arbiter with NUM_REQ=4 and HOLD_MAX=16.
module tb_sync_req_arbiter;

    logic       tb_clk;
    logic       n_rst;
    logic [3:0] async_req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout;

    int n_compared;
    int n_mismatched;

    sync_req_arbiter #(.NUM_REQ(4), .HOLD_MAX(16)) dut (
        .clk      (tb_clk),
        .n_rst    (n_rst),
        .async_req(async_req),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst     = 1'b0;
        async_req = 4'b0000;
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge tb_clk);
        n_rst     = 1'b0;
        async_req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_compared++;
            if ({grant, busy, timeout, grant_id} !== 8'h00) begin
                n_mismatched++;
                $display("[TB] FAIL reset_hold cycle %0d: grant=%b busy=%b timeout=%b id=%0d, required all 0",
                         c, grant, busy, timeout, grant_id);
            end
        end
        @(negedge tb_clk);
        n_rst = 1'b1;
        tick();
        tick();
        n_compared++;
        if (grant !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_edge2: grant=%b, required 0000", grant);
        end
        tick();
        n_compared++;
        if (grant !== 4'b0001 || grant_id !== 2'd0 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_edge3: grant=%b id=%0d busy=%b, required 0001 0 1", grant, grant_id, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge tb_clk);
        async_req = 4'b0100;
        tick();
        tick();
        n_compared++;
        if (grant !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL single_early: grant=%b, required 0000 after edge N+1", grant);
        end
        tick();
        n_compared++;
        if (grant !== 4'b0100 || grant_id !== 2'd2 || busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_grant: grant=%b id=%0d busy=%b, required 0100 2 1", grant, grant_id, busy);
        end
        @(negedge tb_clk);
        async_req = 4'b0000;
        tick();
        tick();
        n_compared++;
        if (grant !== 4'b0100) begin
            n_mismatched++;
            $display("[TB] FAIL single_drop_edge2: grant=%b, required 0100", grant);
        end
        tick();
        n_compared++;
        if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0 || timeout !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_release: grant=%b busy=%b id=%0d timeout=%b, required 0000 0 0 0",
                     grant, busy, grant_id, timeout);
        end
        tick();
        n_compared++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL single_idle: grant=%b busy=%b, required 0000 0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] expected_order [5];
        bit         got;
        int         k;
        expected_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        @(negedge tb_clk);
        async_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                tick();
                if (grant !== 4'b0000) got = 1'b1;
            end
            n_compared++;
            if (!got || grant_id !== expected_order[g] || grant !== (4'b0001 << expected_order[g])) begin
                n_mismatched++;
                $display("[TB] FAIL rr_grant%0d: grant=%b id=%0d, required id %0d one-hot",
                         g, grant, grant_id, expected_order[g]);
            end
            k = int'(expected_order[g]);
            tick();
            tick();
            async_req[k] = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                tick();
                if (grant === 4'b0000) got = 1'b1;
            end
            n_compared++;
            if (!got) begin
                n_mismatched++;
                $display("[TB] FAIL rr_release%0d: grant=%b, required 0000 within 10 edges", g, grant);
            end
            async_req[k] = 1'b1;
        end
    endtask

    task automatic test_watchdog();
        bit got;
        bit regrant;
        int held;
        do_reset();
        @(negedge tb_clk);
        async_req = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (grant === 4'b0010) got = 1'b1;
        end
        held = 1;
        for (int c = 0; c < 40 && grant === 4'b0010; c++) begin
            tick();
            if (grant === 4'b0010) held++;
        end
        n_compared++;
        if (!got || held != 16) begin
            n_mismatched++;
            $display("[TB] FAIL wd_hold_len: held=%0d cycles (granted=%b), required 16", held, got);
        end
        n_compared++;
        if (timeout !== 1'b1 || grant !== 4'b0000 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL wd_timeout: timeout=%b grant=%b busy=%b, required 1 0000 0", timeout, grant, busy);
        end
        tick();
        n_compared++;
        if (timeout !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL wd_pulse_width: timeout=%b, required 0", timeout);
        end
        regrant = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (grant !== 4'b0000) regrant = 1'b1;
        end
        n_compared++;
        if (regrant) begin
            n_mismatched++;
            $display("[TB] FAIL wd_lockout: regrant=%b, required 0 while request held", regrant);
        end
        async_req = 4'b0000;
        tick();
        tick();
        tick();
        async_req = 4'b0010;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (grant !== 4'b0000) got = 1'b1;
        end
        n_compared++;
        if (!got || grant !== 4'b0010 || grant_id !== 2'd1) begin
            n_mismatched++;
            $display("[TB] FAIL wd_regrant: grant=%b id=%0d, required 0010 1", grant, grant_id);
        end
        async_req = 4'b0000;
    endtask

    task automatic test_reset_mid_grant();
        bit got;
        do_reset();
        @(negedge tb_clk);
        async_req = 4'b1000;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (grant === 4'b1000) got = 1'b1;
        end
        n_compared++;
        if (!got) begin
            n_mismatched++;
            $display("[TB] FAIL mid_setup: grant=%b, required 1000", grant);
        end
        n_rst = 1'b0;
        tick();
        n_compared++;
        if (grant !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset: grant=%b busy=%b id=%0d, required 0000 0 0", grant, busy, grant_id);
        end
        n_rst = 1'b1;
        tick();
        tick();
        n_compared++;
        if (grant !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL mid_resync: grant=%b, required 0000", grant);
        end
        tick();
        n_compared++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            n_mismatched++;
            $display("[TB] FAIL mid_regrant: grant=%b id=%0d, required 1000 3", grant, grant_id);
        end
    endtask

    task automatic test_metastable();
        do_reset();
        @(negedge tb_clk);
        async_req = 4'bxxxx;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c >= 2) begin
                n_compared++;
                if ($isunknown(grant) || !$onehot0(grant)) begin
                    n_mismatched++;
                    $display("[TB] FAIL meta_cycle%0d: grant=%b, required zero or one-hot", c, grant);
                end
            end
        end
        async_req = 4'b0000;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        n_rst        = 1'b0;
        async_req    = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_reset_mid_grant();
        test_metastable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
